spi_slave: RTL and testbench

- SPI responder for the team's SPI link; pairs with the existing master (frame width m, MSB first, SCLK idle low, LOAD high = idle/select inactive).
- Oversamples LOAD, SCLK and MOSI in the local clk domain and shifts in an m-bit word.
- Simultaneously shifts out a local m-bit word on MISO; presents the received word on DO with a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_if.sv | 22 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_slave.sv | 122 ++++++++++++
 tb/tb_spi_slave.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    localparam int   SPI_M    = 9;
    localparam logic LOAD_RST = 1'b1;
    localparam logic SCLK_RST = 1'b0;
    localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and word bundle; FERR present under SPI_SLAVE_FERR_EN
interface spi_slave_if #(
    parameter int m = spi_pkg::SPI_M
);
    logic         LOAD;
    logic         SCLK;
    logic         MOSI;
    logic         MISO;
    logic [m-1:0] DI;
    logic [m-1:0] DO;
    logic         DV;
    logic         BUSY;
`ifdef SPI_SLAVE_FERR_EN
    logic         FERR;

    modport slave  (input  LOAD, SCLK, MOSI, DI, output MISO, DO, DV, BUSY, FERR);
    modport master (output LOAD, SCLK, MOSI, DI, input  MISO, DO, DV, BUSY, FERR);
`else
    modport slave  (input  LOAD, SCLK, MOSI, DI, output MISO, DO, DV, BUSY);
    modport master (output LOAD, SCLK, MOSI, DI, input  MISO, DO, DV, BUSY);
`endif
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - NSYNC-flop synchronizer with registered rise/fall detect
module spi_sync #(
    parameter int   NSYNC   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [NSYNC-1:0] sync_q;
    logic             prev_q;

    assign level = sync_q[NSYNC-1];

    // Edges compare the last sync stage against one further flop and are
    // registered, so an edge is reported NSYNC+1 clocks after the pin moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {NSYNC{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[NSYNC-2:0], din};
            prev_q <= sync_q[NSYNC-1];
            rise   <= sync_q[NSYNC-1] & ~prev_q;
            fall   <= ~sync_q[NSYNC-1] & prev_q;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI responder, MSB first; SPI_SLAVE_FERR_EN adds FERR
module spi_slave
    import spi_pkg::*;
#(
    parameter int m     = SPI_M,
    parameter int NSYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(m + 1);

    logic load_level, load_rise, load_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync #(.NSYNC(NSYNC), .RST_VAL(LOAD_RST)) u_load (
        .clk(clk), .rst_n(rst_n), .din(bus.LOAD),
        .level(load_level), .rise(load_rise), .fall(load_fall));
    spi_sync #(.NSYNC(NSYNC), .RST_VAL(SCLK_RST)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(bus.SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.NSYNC(NSYNC), .RST_VAL(MOSI_RST)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(bus.MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

    assign sync_unused = load_level ^ sclk_level ^ mosi_rise ^ mosi_fall;

    spi_state_t    state_q, state_d;
    logic [m-1:0]  rx_q, rx_d, tx_q, tx_d, do_q, do_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          miso_q, miso_d, dv_q, dv_d;
    logic          frame_err;

    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        do_d      = do_q;
        miso_d    = miso_q;
        dv_d      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_fall) begin
                    tx_d    = bus.DI;
                    miso_d  = bus.DI[m-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // LOAD rise beats a coincident SCLK rise; the partial word is dropped.
                if (load_rise) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = (rx_q << 1) | {{(m-1){1'b0}}, mosi_level};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(m - 1)) begin
                        do_d    = rx_d;
                        dv_d    = 1'b1;
                        state_d = DONE;
                    end
                end else if (sclk_fall) begin
                    tx_d   = tx_q << 1;
                    miso_d = tx_q[m-2];
                end
            end
            DONE: begin
                if (load_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    frame_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rx_q    <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            do_q    <= '0;
            miso_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            do_q    <= do_d;
            miso_q  <= miso_d;
            dv_q    <= dv_d;
        end
    end

    assign bus.MISO = miso_q;
    assign bus.DO   = do_q;
    assign bus.DV   = dv_q;
    assign bus.BUSY = (state_q != IDLE);

`ifdef SPI_SLAVE_FERR_EN
    logic ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ferr_q <= 1'b0;
        else        ferr_q <= frame_err;
    end

    assign bus.FERR = ferr_q;
`else
    logic ferr_unused;
    assign ferr_unused = frame_err;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    localparam int M     = 9;
    localparam int NSYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   dv_cnt = 0;
    int   dv_cyc = 0;
    int   ferr_cnt = 0;
    int   rise_cyc = 0;

    spi_slave_if #(.m(M)) bus ();

    spi_slave #(.m(M), .NSYNC(NSYNC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DV === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
`ifdef SPI_SLAVE_FERR_EN
        if (bus.FERR === 1'b1) ferr_cnt = ferr_cnt + 1;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends word[nbits-1:0] MSB first; MISO is sampled at the end of each high phase.
    task automatic frame(input logic [15:0] word, input int nbits, input int half,
                         input logic [M-1:0] di_mid, input bit end_frame,
                         output logic [15:0] miso_bits);
        miso_bits = '0;
        bus.LOAD  = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = word[nbits-1-i];
            wait_clk(half);
            bus.SCLK = 1'b1;
            rise_cyc = cyc;
            if (i == 0) bus.DI = di_mid;
            wait_clk(half);
            miso_bits = {miso_bits[14:0], bus.MISO};
            bus.SCLK  = 1'b0;
        end
        wait_clk(half);
        if (end_frame) begin
            bus.LOAD = 1'b1;
            wait_clk(8);
        end
    endtask

    logic [15:0] mb;
    int          dv0;
    int          fe0;

    initial begin
        rst_n    = 1'b0;
        bus.LOAD = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        bus.DI   = '0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        check("reset_do", 32'(bus.DO), 32'h0);
        check("reset_dv", 32'(bus.DV), 32'h0);
        check("reset_busy", 32'(bus.BUSY), 32'h0);
        check("reset_miso", 32'(bus.MISO), 32'h0);

        bus.DI = 9'h1A5;
        dv0 = dv_cnt;
        frame(16'h00F3, 9, 5, 9'h1A5, 1'b1, mb);
        check("normal_do", 32'(bus.DO), 32'h0F3);
        check("normal_dv", 32'(dv_cnt - dv0), 32'd1);
        check("normal_miso", 32'(mb[8:0]), 32'h1A5);
        check("normal_busy", 32'(bus.BUSY), 32'h0);

        bus.DI = 9'h0C3;
        dv0 = dv_cnt;
        frame(16'h0155, 9, 5, 9'h1FF, 1'b1, mb);
        check("b2b1_do", 32'(bus.DO), 32'h155);
        check("b2b1_miso", 32'(mb[8:0]), 32'h0C3);
        frame(16'h00AA, 9, 5, 9'h1FF, 1'b1, mb);
        check("b2b2_do", 32'(bus.DO), 32'h0AA);
        check("b2b2_miso", 32'(mb[8:0]), 32'h1FF);
        check("b2b_dv", 32'(dv_cnt - dv0), 32'd2);

        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        frame(16'h000F, 4, 5, 9'h1FF, 1'b1, mb);
        check("abort_do", 32'(bus.DO), 32'h0AA);
        check("abort_dv", 32'(dv_cnt - dv0), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'h0);
`ifdef SPI_SLAVE_FERR_EN
        check("abort_ferr", 32'(ferr_cnt - fe0), 32'd1);
`endif
        dv0 = dv_cnt;
        frame(16'h0003, 9, 5, 9'h1FF, 1'b1, mb);
        check("post_abort_do", 32'(bus.DO), 32'h003);
        check("post_abort_dv", 32'(dv_cnt - dv0), 32'd1);

        bus.DI = 9'h0AA;
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        frame(16'h070F, 11, 5, 9'h0AA, 1'b1, mb);
        check("over_do", 32'(bus.DO), 32'h1C3);
        check("over_dv", 32'(dv_cnt - dv0), 32'd1);
        check("over_miso", 32'(mb[10:0]), 32'h2A8);
`ifdef SPI_SLAVE_FERR_EN
        check("over_ferr", 32'(ferr_cnt - fe0), 32'd2);
`endif

        bus.DI = 9'h1FF;
        frame(16'h001F, 5, 5, 9'h1FF, 1'b0, mb);
        check("mid_miso", 32'(bus.MISO), 32'h1);
        check("mid_busy", 32'(bus.BUSY), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_do", 32'(bus.DO), 32'h0);
        check("rst_dv", 32'(bus.DV), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        check("rst_miso", 32'(bus.MISO), 32'h0);
        bus.LOAD = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        frame(16'h0111, 9, 5, 9'h1FF, 1'b1, mb);
        check("after_rst_do", 32'(bus.DO), 32'h111);

        dv0 = dv_cnt;
        frame(16'h00FF, 9, NSYNC + 2, 9'h1FF, 1'b1, mb);
        check("min_do", 32'(bus.DO), 32'h0FF);
        check("min_dv", 32'(dv_cnt - dv0), 32'd1);
        check("min_latency", 32'(dv_cyc - rise_cyc), 32'(NSYNC + 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
